// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, 8N1 frame constants
// and the bit-timing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic        START_BIT   = 1'b0;
    localparam logic        STOP_BIT    = 1'b1;
    localparam int unsigned FRAME_DBITS = 8;
    localparam int unsigned FRAME_SBITS = 1;

    function automatic int unsigned clks_per_bit(input int unsigned src_clk,
                                                 input int unsigned baud);
        return src_clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side consumer interface: byte handshake, sticky error flags and status.
interface uart_rx_if #(parameter int unsigned DATA_W = 8);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
    logic              clr_err;
    logic              busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready, clr_err
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready, clr_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input (ftdi_rx, pushbuttons).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= {2{RST_VAL}};
        else          r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits timed from hwclk, one-entry holding
// register on a valid/ready handshake, sticky framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SOURCE_CLK = 12000000,
    parameter int unsigned TARGET_CLK = 9600,
    parameter int unsigned CNTR_W     = 32,
    parameter int unsigned DATA_W     = 8
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       ftdi_rx,
    uart_rx_if.master  rx
);

    localparam int unsigned       CPB_I    = clks_per_bit(SOURCE_CLK, TARGET_CLK);
    localparam logic [CNTR_W-1:0] CPB_M1   = CNTR_W'(CPB_I - 1);
    localparam logic [CNTR_W-1:0] HALF_M1  = CNTR_W'(CPB_I / 2 - 1);
    localparam int unsigned       IDX_W    = $clog2(DATA_W + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_W - 1);

    if (CPB_I < 4) begin : g_bad_cpb
        $error("uart_rx: SOURCE_CLK/TARGET_CLK must be at least 4");
    end

    uart_state_t       r_state, w_next;
    logic [CNTR_W-1:0] r_cnt;
    logic [CNTR_W-1:0] w_limit;
    logic              w_tick;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_data;
    logic              r_valid, r_frame_err, r_overrun;
    logic              w_rxs, w_busy, w_shift, w_stop_smp, w_deliver, w_bad_stop;
    logic              w_load;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk   (hwclk),
        .i_rst_n (rst_n),
        .i_d     (ftdi_rx),
        .o_q     (w_rxs)
    );

    // START waits half a bit so every later sample lands at bit centre
    assign w_limit = (r_state == START) ? HALF_M1 : CPB_M1;
    assign w_tick  = (r_cnt == w_limit);

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_rxs == START_BIT) w_next = START;
            START:   if (w_tick) w_next = (w_rxs == START_BIT) ? DATA : IDLE;
            DATA:    if (w_tick && (r_bit_idx == LAST_IDX)) w_next = STOP;
            STOP:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != IDLE);
        w_shift    = (r_state == DATA) && w_tick;
        w_stop_smp = (r_state == STOP) && w_tick;
        w_deliver  = w_stop_smp && (w_rxs == STOP_BIT);
        w_bad_stop = w_stop_smp && (w_rxs != STOP_BIT);
        w_load     = w_deliver && (!r_valid || rx.rx_ready);
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            r_cnt <= ((r_state == IDLE) || w_tick) ? '0 : r_cnt + 1'b1;
            if (r_state == START) r_bit_idx <= '0;
            else if (w_shift)     r_bit_idx <= r_bit_idx + 1'b1;
            if (w_shift) r_shreg <= {w_rxs, r_shreg[DATA_W-1:1]};
        end
    end

    // a byte arriving on the same edge the old one is taken refills the slot
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
            end else if (r_valid && rx.rx_ready) begin
                r_valid <= 1'b0;
            end
            if (w_deliver && !w_load) r_overrun <= 1'b1;
            else if (rx.clr_err)      r_overrun <= 1'b0;
            if (w_bad_stop)           r_frame_err <= 1'b1;
            else if (rx.clr_err)      r_frame_err <= 1'b0;
        end
    end

    assign rx.rx_data   = r_data;
    assign rx.rx_valid  = r_valid;
    assign rx.frame_err = r_frame_err;
    assign rx.overrun   = r_overrun;
    assign rx.busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at CPB=16: frames built from the 8N1
// rule, expected bytes queued at send time and checked by an independent monitor.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned SRC  = 160;
    localparam int unsigned BAUD = 10;
    localparam int unsigned CPB  = SRC / BAUD;
    localparam int unsigned HALF = CPB / 2;
    // stop sample after HALF+9*CPB, plus two synchronizer stages and the IDLE detect edge
    localparam int unsigned LAT  = HALF + 9 * CPB + 3;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic rx_line = 1'b1;

    uart_rx_if #(.DATA_W(8)) bus ();

    uart_rx #(
        .SOURCE_CLK (SRC),
        .TARGET_CLK (BAUD),
        .CNTR_W     (32),
        .DATA_W     (8)
    ) dut (
        .hwclk   (clk),
        .rst_n   (rst_n),
        .ftdi_rx (rx_line),
        .rx      (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_q[$];
    int unsigned rise_cyc   = 0;
    int unsigned rises      = 0;
    int unsigned pulse_len  = 0;
    int unsigned last_pulse = 0;
    logic        prev_valid = 1'b0;
    logic        holding    = 1'b0;
    logic [7:0]  held       = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: scoreboard pop on every accepted transfer, data held while stalled
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
            holding    = 1'b0;
            pulse_len  = 0;
        end else begin
            if (bus.rx_valid && !prev_valid) begin
                rise_cyc = cyc;
                rises++;
            end
            if (bus.rx_valid) pulse_len++;
            else if (prev_valid) begin
                last_pulse = pulse_len;
                pulse_len  = 0;
            end
            if (holding) chk("hold_data", bus.rx_data, held);
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got byte 0x%0h expected none", bus.rx_data);
                end else begin
                    chk("sb_data", bus.rx_data, exp_q.pop_front());
                end
                holding = 1'b0;
            end else if (bus.rx_valid) begin
                holding = 1'b1;
                held    = bus.rx_data;
            end else begin
                holding = 1'b0;
            end
            prev_valid = bus.rx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // LSB-first serialisation; jit lengthens odd bits and shortens even ones
    task automatic send_raw(input logic [9:0] f, input int jit);
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            tick(int'(CPB) + (((i % 2) == 1) ? jit : -jit));
        end
        rx_line = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stopb, input int jit,
                             input bit deliver);
        if (deliver) exp_q.push_back(d);
        send_raw({stopb, d, START_BIT}, jit);
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            tick(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        logic [9:0]  f;
        logic [7:0]  sk[3];
        int unsigned t0, r0;
        logic [7:0]  d;
        int          jit, gap;

        bus.rx_ready = 1'b0;
        bus.clr_err  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick(3);

        // single frame 10'b1010000010, latency and pulse width
        bus.rx_ready = 1'b1;
        r0 = rises;
        t0 = cyc;
        f  = 10'b1010000010;
        exp_q.push_back(8'h41);
        send_raw(f, 0);
        tick(4);
        chk("t1_rises", rises - r0, 1);
        chk("t1_latency", rise_cyc - t0, LAT);
        chk("t1_pulse", last_pulse, 1);
        chk("t1_frame_err", bus.frame_err, 0);
        wait_drain(50, "t1_drain");

        // back-to-back with consumer stalled: first byte held, second dropped
        bus.rx_ready = 1'b0;
        send_byte(8'h55, STOP_BIT, 0, 1'b1);
        send_byte(8'hAA, STOP_BIT, 0, 1'b0);
        tick(2);
        chk("t2_overrun", bus.overrun, 1);
        chk("t2_valid", bus.rx_valid, 1);
        chk("t2_data", bus.rx_data, 8'h55);
        bus.rx_ready = 1'b1;
        tick(1);
        chk("t2_valid_fall", bus.rx_valid, 0);
        wait_drain(10, "t2_drain");
        chk("t2_overrun_sticky", bus.overrun, 1);
        pulse_clr();
        chk("t2_overrun_clr", bus.overrun, 0);

        // bad stop bit, then a good frame
        r0 = rises;
        send_byte(8'h3C, ~STOP_BIT, 0, 1'b0);
        tick(2);
        chk("t3_frame_err", bus.frame_err, 1);
        chk("t3_no_valid", rises - r0, 0);
        send_byte(8'h12, STOP_BIT, 0, 1'b1);
        wait_drain(50, "t3_drain");
        chk("t3_frame_err_sticky", bus.frame_err, 1);
        pulse_clr();
        chk("t3_frame_err_clr", bus.frame_err, 0);

        // short glitch
        r0 = rises;
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        chk("t4_busy_start", bus.busy, 1);
        tick(20);
        chk("t4_busy_idle", bus.busy, 0);
        chk("t4_no_valid", rises - r0, 0);
        chk("t4_frame_err", bus.frame_err, 0);
        chk("t4_overrun", bus.overrun, 0);

        // reset mid-frame with a held byte and a raised flag
        bus.rx_ready = 1'b0;
        send_byte(8'h99, ~STOP_BIT, 0, 1'b0);
        tick(2);
        send_byte(8'h99, STOP_BIT, 0, 1'b1);
        tick(2);
        chk("t5_pre_valid", bus.rx_valid, 1);
        f = {STOP_BIT, 8'hF0, START_BIT};
        for (int i = 0; i < 4; i++) begin
            rx_line = f[i];
            tick(int'(CPB));
        end
        rx_line = f[4];
        tick(int'(HALF));
        chk("t5_pre_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t5_valid", bus.rx_valid, 0);
        chk("t5_data", bus.rx_data, 0);
        chk("t5_frame_err", bus.frame_err, 0);
        chk("t5_overrun", bus.overrun, 0);
        chk("t5_busy", bus.busy, 0);
        rx_line = 1'b1;
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        bus.rx_ready = 1'b1;
        send_byte(8'hF0, STOP_BIT, 0, 1'b1);
        wait_drain(50, "t5_drain");

        // bit-period jitter of one clock
        sk[0] = 8'h00;
        sk[1] = 8'hFF;
        sk[2] = 8'hA5;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 3; k++) begin
                send_byte(sk[k], STOP_BIT, (j == 0) ? -1 : 1, 1'b1);
            end
        end
        wait_drain(50, "t6_drain");

        // random bytes, random jitter and gaps
        for (int k = 0; k < 10; k++) begin
            d   = 8'($urandom);
            jit = int'($urandom_range(0, 2)) - 1;
            gap = int'($urandom_range(0, 20));
            send_byte(d, STOP_BIT, jit, 1'b1);
            if (gap > 0) tick(gap);
        end
        wait_drain(50, "rand_drain");
        chk("end_frame_err", bus.frame_err, 0);
        chk("end_overrun", bus.overrun, 0);
        chk("end_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end

endmodule
